// File: rtl/osc_phase_core.sv
// Phase-accumulator oscillator producing square, triangle, saw and LFSR-noise samples.
// Waveform select and duty are shadowed and only retaken at phase wrap, sync or while disabled.
module osc_phase_core #(
    parameter int unsigned WAVE_WIDTH_P  = 24,
    parameter int unsigned PHASE_WIDTH_P = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [WAVE_WIDTH_P-1:0]  waveform,
    output logic                     waveform_valid,
    output logic                     phase_wrap,
    input  logic                     cr_enable,
    input  logic                     cr_sync,
    input  logic [1:0]               cr_waveform_select,
    input  logic [PHASE_WIDTH_P-1:0] cr_frequency,
    input  logic [PHASE_WIDTH_P-1:0] cr_duty_cycle
);

    localparam int unsigned WW         = WAVE_WIDTH_P;
    localparam int unsigned PW         = PHASE_WIDTH_P;
    localparam int unsigned LFSR_W     = 32;
    localparam int unsigned FRAC_W     = PW - WW;
    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(32'h0000_0001);

    // Keeps only the top WW phase bits so the duty compare ignores sub-sample resolution.
    localparam logic [PW-1:0] PHASE_MASK = ~(PW'((64'd1 << FRAC_W) - 64'd1));

    localparam logic [1:0] SEL_SQUARE   = 2'd0;
    localparam logic [1:0] SEL_TRIANGLE = 2'd1;
    localparam logic [1:0] SEL_SAW      = 2'd2;
    localparam logic [1:0] SEL_NOISE    = 2'd3;

    if (WAVE_WIDTH_P < 2 || WAVE_WIDTH_P > 32 || WAVE_WIDTH_P > PHASE_WIDTH_P) begin : g_bad_params
        $error("osc_phase_core: WAVE_WIDTH_P must be 2..32 and <= PHASE_WIDTH_P");
    end

    logic [PW-1:0]     phase_q,          phase_d;
    logic [1:0]        shadow_select_q,  shadow_select_d;
    logic [PW-1:0]     shadow_duty_q,    shadow_duty_d;
    logic [LFSR_W-1:0] lfsr_q,           lfsr_d;
    logic [WW-1:0]     waveform_q,       waveform_d;
    logic              waveform_valid_q, waveform_valid_d;
    logic              phase_wrap_q,     phase_wrap_d;

    logic [PW:0]       phase_sum_c;
    logic              carry_c;
    logic [LFSR_W-1:0] lfsr_next_c;
    logic [WW-1:0]     p_c;
    logic [WW-1:0]     tri_c;
    logic              square_hi_c;
    logic [WW-1:0]     sample_c;

    // Accumulator sum with carry out, and the next LFSR state.
    always_comb begin
        phase_sum_c = {1'b0, phase_q} + {1'b0, cr_frequency};
        carry_c     = phase_sum_c[PW];
        lfsr_next_c = {lfsr_q[LFSR_W-2:0],
                       lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    // Sample from the current phase register and shadowed controls.
    always_comb begin
        p_c         = phase_q[PW-1 -: WW];
        tri_c       = {p_c[WW-2:0], 1'b0};
        square_hi_c = (phase_q & PHASE_MASK) < (shadow_duty_q & PHASE_MASK);
        sample_c    = '0;
        case (shadow_select_q)
            SEL_SQUARE:   sample_c = square_hi_c ? {WW{1'b1}} : {WW{1'b0}};
            SEL_TRIANGLE: sample_c = p_c[WW-1] ? ~tri_c : tri_c;
            SEL_SAW:      sample_c = p_c;
            SEL_NOISE:    sample_c = lfsr_q[LFSR_W-1 -: WW];
            default:      sample_c = '0;
        endcase
    end

    // Sync beats enable; shadows also follow the inputs whenever the core is idle.
    always_comb begin
        phase_d          = phase_q;
        shadow_select_d  = shadow_select_q;
        shadow_duty_d    = shadow_duty_q;
        lfsr_d           = lfsr_q;
        waveform_d       = waveform_q;
        waveform_valid_d = 1'b0;
        phase_wrap_d     = 1'b0;

        if (cr_sync) begin
            phase_d          = '0;
            shadow_select_d  = cr_waveform_select;
            shadow_duty_d    = cr_duty_cycle;
            phase_wrap_d     = 1'b1;
            waveform_d       = sample_c;
            waveform_valid_d = 1'b1;
        end else if (cr_enable) begin
            phase_d          = phase_sum_c[PW-1:0];
            waveform_d       = sample_c;
            waveform_valid_d = 1'b1;
            if (carry_c) begin
                shadow_select_d = cr_waveform_select;
                shadow_duty_d   = cr_duty_cycle;
                lfsr_d          = lfsr_next_c;
                phase_wrap_d    = 1'b1;
            end
        end else begin
            shadow_select_d = cr_waveform_select;
            shadow_duty_d   = cr_duty_cycle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q          <= '0;
            shadow_select_q  <= SEL_SQUARE;
            shadow_duty_q    <= '0;
            lfsr_q           <= LFSR_SEED;
            waveform_q       <= '0;
            waveform_valid_q <= 1'b0;
            phase_wrap_q     <= 1'b0;
        end else begin
            phase_q          <= phase_d;
            shadow_select_q  <= shadow_select_d;
            shadow_duty_q    <= shadow_duty_d;
            lfsr_q           <= lfsr_d;
            waveform_q       <= waveform_d;
            waveform_valid_q <= waveform_valid_d;
            phase_wrap_q     <= phase_wrap_d;
        end
    end

    assign waveform       = waveform_q;
    assign waveform_valid = waveform_valid_q;
    assign phase_wrap     = phase_wrap_q;

endmodule

// File: tb/tb_osc_phase_core.sv
// Self-checking bench for osc_phase_core (W=8, PHASE=16): vector table, directed corners, random vs model.
module tb_osc_phase_core;

    localparam int unsigned W = 8;
    localparam int unsigned P = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  waveform;
    logic          waveform_valid;
    logic          phase_wrap;
    logic          en   = 1'b0;
    logic          sync = 1'b0;
    logic [1:0]    sel  = 2'd0;
    logic [P-1:0]  freq = '0;
    logic [P-1:0]  duty = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (spec-level quantities as plain integers)
    int          m_phase, m_sel, m_duty;
    logic [31:0] m_lfsr;
    int          e_wave, e_valid, e_wrap;

    osc_phase_core #(.WAVE_WIDTH_P(W), .PHASE_WIDTH_P(P)) dut (
        .clk                (clk),
        .rst                (rst),
        .waveform           (waveform),
        .waveform_valid     (waveform_valid),
        .phase_wrap         (phase_wrap),
        .cr_enable          (en),
        .cr_sync            (sync),
        .cr_waveform_select (sel),
        .cr_frequency       (freq),
        .cr_duty_cycle      (duty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [1:0]   sel;
        logic [P-1:0] freq;
        int           wave;
        int           valid;
        int           wrap;
    } vec_t;
    vec_t vt[18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        int fb;
        fb = int'(((l >> 31) ^ (l >> 21) ^ (l >> 1) ^ l) & 32'd1);
        return (l << 1) | 32'(fb);
    endfunction

    function automatic int ref_sample(input int ph, input int s, input int d, input logic [31:0] l);
        int p, dd;
        p  = ph / 256;
        dd = d / 256;
        case (s)
            0:       return (p < dd) ? 255 : 0;
            1:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            2:       return p;
            default: return int'(l / 32'h0100_0000);
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_duty = 0; m_lfsr = 32'h1;
        e_wave = 0; e_valid = 0; e_wrap = 0;
    endtask

    task automatic model_step();
        int s, sum;
        s = ref_sample(m_phase, m_sel, m_duty, m_lfsr);
        if (sync) begin
            e_wave = s; e_valid = 1; e_wrap = 1;
            m_phase = 0; m_sel = int'(sel); m_duty = int'(duty);
        end else if (en) begin
            e_wave = s; e_valid = 1;
            sum = m_phase + int'(freq);
            e_wrap = (sum > 65535) ? 1 : 0;
            if (e_wrap == 1) begin
                m_sel = int'(sel); m_duty = int'(duty);
                m_lfsr = lfsr_step(m_lfsr);
            end
            m_phase = sum % 65536;
        end else begin
            e_valid = 0; e_wrap = 0;
            m_sel = int'(sel); m_duty = int'(duty);
        end
    endtask

    // One clock: advance model with the applied inputs and compare all outputs against it.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check("model_wave",  int'(waveform),       e_wave);
        check("model_valid", int'(waveform_valid), e_valid);
        check("model_wrap",  int'(phase_wrap),     e_wrap);
    endtask

    task automatic pulse_sync(input logic [1:0] s, input logic [P-1:0] d);
        sync = 1'b1; sel = s; duty = d;
        step();
        check("sync_wrap", int'(phase_wrap), 1);
        sync = 1'b0;
    endtask

    initial begin
        model_reset();
        vt[0] = '{en: 1'b0, sel: 2'd2, freq: 16'h1000, wave: 0, valid: 0, wrap: 0};
        for (int i = 1; i < 18; i++)
            vt[i] = '{en: 1'b1, sel: 2'd2, freq: 16'h1000,
                      wave: ((i - 1) * 16) % 256, valid: 1, wrap: (i == 16) ? 1 : 0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_wave",  int'(waveform), 0);
        check("reset_valid", int'(waveform_valid), 0);
        check("reset_wrap",  int'(phase_wrap), 0);
        rst = 1'b0;

        // Saw at 1/16 clock rate from the vector table
        for (int i = 0; i < 18; i++) begin
            en = vt[i].en; sel = vt[i].sel; freq = vt[i].freq;
            step();
            check("vec_wave",  int'(waveform),       vt[i].wave);
            check("vec_valid", int'(waveform_valid), vt[i].valid);
            check("vec_wrap",  int'(phase_wrap),     vt[i].wrap);
        end

        // Triangle
        pulse_sync(2'd1, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            step();
            check("tri_wave", int'(waveform), (k < 8) ? 32 * k : 511 - 32 * k);
        end

        // Square with quarter duty, then zero duty
        pulse_sync(2'd0, 16'h4000);
        for (int k = 0; k < 16; k++) begin
            step();
            check("sq25_wave", int'(waveform), (k < 4) ? 255 : 0);
        end
        pulse_sync(2'd0, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            step();
            check("sq0_wave", int'(waveform), 0);
        end

        // Select change mid-period waits for the next wrap
        pulse_sync(2'd0, 16'h4000);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) sel = 2'd2;
            step();
            check("midsel_wave", int'(waveform), (k < 4) ? 255 : 0);
            if (k == 15) check("midsel_wrap", int'(phase_wrap), 1);
        end
        step();
        check("midsel_saw0", int'(waveform), 8'h00);
        step();
        check("midsel_saw1", int'(waveform), 8'h10);

        // Enable drop holds everything; sync overrides disable
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_wave",  int'(waveform), 8'h10);
            check("hold_valid", int'(waveform_valid), 0);
        end
        pulse_sync(2'd2, 16'h0000);
        check("sync_dis_valid", int'(waveform_valid), 1);
        check("sync_dis_wave",  int'(waveform), 8'h20);
        en = 1'b1;
        step();
        check("post_sync_wave", int'(waveform), 8'h00);

        // Asynchronous reset mid-period
        step(); step();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_wave",  int'(waveform), 0);
        check("async_rst_valid", int'(waveform_valid), 0);
        check("async_rst_wrap",  int'(phase_wrap), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Noise after reset: selection taken at first wrap
        sel = 2'd3; freq = 16'h1000; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 15) check("noise_wrap", int'(phase_wrap), 1);
        end
        check("noise_lfsr_model", int'(m_lfsr), 3);

        // Constrained-random against the model
        for (int n = 0; n < 3000; n++) begin
            en   = ($urandom % 8) != 0;
            sync = ($urandom % 64) == 0;
            if ($urandom % 16 == 0) sel = 2'($urandom % 4);
            case ($urandom % 4)
                0:       freq = '0;
                1:       freq = P'($urandom % 256);
                default: freq = P'($urandom);
            endcase
            if ($urandom % 8 == 0) duty = P'($urandom);
            step();
        end
        sync = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/osc_phase_core.md
Name: osc_phase_core

Overview:
Next-generation single-channel oscillator core built on a phase accumulator.
- Generates square (programmable duty), triangle, sawtooth and LFSR noise waveforms from one N-bit phase register.
- Waveform and duty changes take effect only at phase wrap, so switching never glitches mid-period.
- Provides hard sync, enable/hold, a sample-valid strobe and a wrap strobe. It feeds the mixer/DAC path in place of counter-per-waveform cores.

Parameters:
WAVE_WIDTH_P, 24, output sample width; legal range 2..32 and must be <= PHASE_WIDTH_P.
PHASE_WIDTH_P, 32, phase accumulator and frequency-word width.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
waveform  output  WAVE_WIDTH_P  registered sample, unsigned offset-binary (0 = minimum, all-ones = maximum)
waveform_valid  output  1  high for one cycle when waveform has been updated
phase_wrap  output  1  high for one cycle after an accumulator overflow or a sync
cr_enable  input  1  1 = advance phase each cycle; 0 = hold phase and waveform
cr_sync  input  1  single-cycle pulse: restart phase at 0
cr_waveform_select  input  2  0 square, 1 triangle, 2 saw, 3 noise
cr_frequency  input  PHASE_WIDTH_P  phase increment per clk; f_out = f_clk*cr_frequency/2^PHASE_WIDTH_P
cr_duty_cycle  input  PHASE_WIDTH_P  square high-time threshold, expressed as a phase value

Behaviour:
- Reset (async assert, sync release): phase=0, shadow_select=0 (square), shadow_duty=0, lfsr=32'h0000_0001, waveform=0, waveform_valid=0, phase_wrap=0. Reset mid-period discards all state immediately.
- Shadow registers shadow_select and shadow_duty load from the cr_* inputs on the edge that registers a wrap or a sync, and also on any edge where cr_enable=0.
- cr_frequency is not shadowed; it takes effect on the next increment.
- Accumulator, on each edge, in priority order:
  - cr_sync=1: phase<=0, shadows load, phase_wrap<=1, lfsr unchanged. Sync overrides cr_enable.
  - cr_enable=1: {carry,phase}<=phase+cr_frequency (modulo 2^PHASE_WIDTH_P). If carry=1: shadows load, lfsr advances once, phase_wrap<=1. Otherwise phase_wrap<=0.
  - Otherwise: phase holds and phase_wrap<=0.
- cr_frequency=0 with enable high: phase is constant, no wraps occur, and the output keeps being re-registered.
- LFSR: 32-bit Fibonacci, shift left, new bit0 = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]. It never reaches 0.
- Sample generation: let p = phase[PHASE_WIDTH_P-1 -: WAVE_WIDTH_P] and d = shadow_duty[PHASE_WIDTH_P-1 -: WAVE_WIDTH_P].
  - square: all-ones if p<d, else 0. d=0 gives constant 0; d=all-ones gives high for every p except all-ones.
  - triangle: t={p[W-2:0],1'b0}. Output is t when p[W-1]=0, else ~t.
  - saw: p.
  - noise: lfsr[31 -: WAVE_WIDTH_P].
- Output register: when cr_enable=1 or the sync path is taken, waveform<=sample(phase register, shadow regs) and waveform_valid<=1. Otherwise both hold and waveform_valid<=0.
  - The sample lags the phase register by one cycle. phase_wrap and the first sample computed from the wrapped phase appear on consecutive cycles.
- A select or duty change mid-period has no effect on the output until the first sample after the next wrap/sync.

Test Plan:
1. W=8, PHASE=16, freq=16'h1000, saw, enable -> waveform cycles 0x00,0x10,...,0xF0, then 0x00. phase_wrap pulses every 16 cycles. waveform_valid is constantly high.
2. Triangle with the same freq -> 0x00,0x20,...,0xE0,0xFF,0xDF,...,0x1F, repeating every 16 samples.
3. Square, duty=16'h4000 -> four samples of 0xFF then twelve of 0x00 per period. Duty=0 -> all 0x00.
4. Write select=saw 5 cycles after a wrap -> square pattern continues until the next phase_wrap, then saw starts at 0x00.
5. Noise select after reset -> lfsr=0x00000003 after the first wrap. waveform changes only after wraps and equals lfsr[31:24].
6. Enable dropped mid-period -> phase and waveform frozen, waveform_valid=0. cr_sync pulse -> phase=0, phase_wrap=1, next sample 0x00 (saw). rst asserted mid-period -> all outputs 0 immediately.
